// File: rtl/debounce_edge_array_pkg.sv
// Shared defaults, the per-channel output record and a width helper for the
// debounce_edge_array slice.
package debounce_edge_array_pkg;

   localparam int SYNC_STAGES_DEFAULT  = 32'sd2;
   localparam int PRESCALE_LG_DEFAULT  = 32'sd10;
   localparam int STABLE_TICKS_DEFAULT = 32'sd16;

   typedef struct packed {
      logic level;
      logic rise;
      logic fall;
   } chan_out_t;

   // Bits needed to count 0..value-1, never less than one bit.
   function automatic int clog2_min1(input int value);
      return (value > 32'sd1) ? $clog2(value) : 32'sd1;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: input synchroniser, stability counter, accepted level
// and registered one-cycle rise/fall pulses.
module debounce_channel
   import debounce_edge_array_pkg::*;
#(
   parameter int SYNC_STAGES  = SYNC_STAGES_DEFAULT,
   parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      raw,
   input  logic      tick,
   input  logic      primed_int,
   output chan_out_t chan
);

   localparam int               CNT_W    = clog2_min1(STABLE_TICKS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 32'sd1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'sd1);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   synced_s;
   logic [CNT_W-1:0]       cnt_r;
   logic                   level_r;
   logic                   rise_r;
   logic                   fall_r;

   assign synced_s = sync_r[SYNC_STAGES-1];

   // Synchroniser shift chain for the asynchronous raw input.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
      end
   end

   // Stability qualification; while unprimed the level tracks the synchroniser
   // so the zero reset state never produces a false edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r   <= '0;
         level_r <= 1'b0;
         rise_r  <= 1'b0;
         fall_r  <= 1'b0;
      end else if (!primed_int) begin
         cnt_r   <= '0;
         level_r <= synced_s;
         rise_r  <= 1'b0;
         fall_r  <= 1'b0;
      end else if (synced_s == level_r) begin
         cnt_r  <= '0;
         rise_r <= 1'b0;
         fall_r <= 1'b0;
      end else if (tick && (cnt_r == CNT_LAST)) begin
         cnt_r   <= '0;
         level_r <= synced_s;
         rise_r  <= synced_s;
         fall_r  <= ~synced_s;
      end else if (tick) begin
         cnt_r  <= cnt_r + CNT_ONE;
         rise_r <= 1'b0;
         fall_r <= 1'b0;
      end else begin
         rise_r <= 1'b0;
         fall_r <= 1'b0;
      end
   end

   assign chan = '{level: level_r, rise: rise_r, fall: fall_r};

endmodule

// File: rtl/debounce_edge_array.sv
// Multi-channel debouncer with per-channel stability counters, a shared tick
// prescaler and a start-up priming window.
module debounce_edge_array
   import debounce_edge_array_pkg::*;
#(
   parameter int WIDTH        = 32'sd4,
   parameter int SYNC_STAGES  = SYNC_STAGES_DEFAULT,
   parameter int PRESCALE_LG  = PRESCALE_LG_DEFAULT,
   parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] raw_in,
   output logic [WIDTH-1:0] debounced_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic             primed
);

   localparam int                 PRIME_W    = clog2_min1(SYNC_STAGES + 32'sd1);
   localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(SYNC_STAGES);
   localparam logic [PRIME_W-1:0] PRIME_ONE  = PRIME_W'(32'sd1);

   logic [PRIME_W-1:0] prime_cnt_r;
   logic               primed_r;
   logic               tick_s;
   chan_out_t          chan_s [WIDTH];

   // Prime counter saturates at SYNC_STAGES; priming ends on that edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prime_cnt_r <= '0;
         primed_r    <= 1'b0;
      end else begin
         primed_r <= (prime_cnt_r == PRIME_LAST);
         if (prime_cnt_r != PRIME_LAST) begin
            prime_cnt_r <= prime_cnt_r + PRIME_ONE;
         end else begin
            prime_cnt_r <= prime_cnt_r;
         end
      end
   end

   assign primed = primed_r;

   generate
      if (PRESCALE_LG == 0) begin : g_no_prescale
         assign tick_s = 1'b1;
      end else begin : g_prescale
         logic [PRESCALE_LG-1:0] presc_r;

         // Free-running prescaler; a tick is the all-ones state.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               presc_r <= '0;
            end else begin
               presc_r <= presc_r + PRESCALE_LG'(32'sd1);
            end
         end

         assign tick_s = &presc_r;
      end

      for (genvar i = 0; i < WIDTH; i++) begin : g_chan
         debounce_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_TICKS (STABLE_TICKS)
         ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .raw        (raw_in[i]),
            .tick       (tick_s),
            .primed_int (primed_r),
            .chan       (chan_s[i])
         );

         assign debounced_out[i] = chan_s[i].level;
         assign rise_pulse[i]    = chan_s[i].rise;
         assign fall_pulse[i]    = chan_s[i].fall;
      end
   endgenerate

endmodule
